// File: rtl/data_mem_latency.sv
// Byte-addressed data memory for the MEM stage with programmable access latency,
// byte-lane write enables and a req/ack handshake; busy_o stalls the pipeline.
module data_mem_latency #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic              accept;
  logic              commit;
  logic              mem_we;

  assign word_idx     = addr_q >> OFF;
  assign idx          = word_idx[IDX_W-1:0];
  assign misaligned   = |(addr_q & ADDR_W'(NB - 1));
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign acc_err      = misaligned | out_of_range;
  assign accept       = req_i & ((state_q == S_IDLE) | (state_q == S_RESP));
  assign commit       = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we       = commit & we_q & ~acc_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
        cnt_q   <= CNT_W'(LATENCY - 1);
        busy_q  <= 1'b1;
        state_q <= S_WAIT;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              state_q <= S_RESP;
              busy_q  <= 1'b0;
              ack_q   <= 1'b1;
              err_q   <= acc_err;
              // Errored accesses return zero; good writes leave rdata alone.
              if (acc_err)    rdata_q <= '0;
              else if (!we_q) rdata_q <= mem_q[idx];
            end
          end
          S_RESP:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Storage is deliberately not reset; only the commit edge writes it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_data_mem_latency.sv
// Bench for data_mem_latency: LATENCY=1 and LATENCY=3 instances checked against a
// byte-level reference memory under directed and random accesses.
module tb_data_mem_latency;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  mb     [2][128];
  bit          mv     [2][128];
  logic [31:0] mrd    [2];
  bit          mrd_v  [2];

  always #5 clk = ~clk;

  data_mem_latency #(.LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
    .err_o(err[0]), .busy_o(busy[0])
  );

  data_mem_latency #(.LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
    .err_o(err[1]), .busy_o(busy[1])
  );

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: applies one access to the byte array, returns expected err.
  function automatic bit model_apply(int s, bit w, logic [31:0] a, logic [31:0] d,
                                     logic [3:0] b);
    bit e;
    int wi;
    e = (a[1:0] != 2'b00) || ((a >> 2) >= 32);
    if (e) begin
      mrd[s]   = 32'h0;
      mrd_v[s] = 1'b1;
      return 1'b1;
    end
    wi = int'(a >> 2);
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) begin
          mb[s][wi*4+i] = d[8*i +: 8];
          mv[s][wi*4+i] = 1'b1;
        end
    end else begin
      mrd_v[s] = mv[s][wi*4] & mv[s][wi*4+1] & mv[s][wi*4+2] & mv[s][wi*4+3];
      mrd[s]   = {mb[s][wi*4+3], mb[s][wi*4+2], mb[s][wi*4+1], mb[s][wi*4]};
    end
    return 1'b0;
  endfunction

  task automatic access(int s, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    int  n;
    int  bc;
    bit  seen;
    bit  eerr;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
    @(posedge clk);
    #1 req[s] = 1'b0;
    n = 0; bc = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (busy[s]) bc++;
      if (ack[s]) seen = 1'b1;
    end
    eerr = model_apply(s, w, a, d, b);
    chk("ack_latency", 32'(n), 32'(lat_of(s) + 1));
    chk("busy_cycles", 32'(bc), 32'(lat_of(s)));
    chk("err", {31'b0, err[s]}, {31'b0, eerr});
    if (mrd_v[s]) chk("rdata", rdata[s], mrd[s]);
    @(negedge clk);
    chk("ack_single", {31'b0, ack[s]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bb_a [3];
    int          ack_t [3];
    int          k;
    int          t;
    int          bc;
    int          extra;

    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0; be[s] = '0;
      mrd[s] = 32'h0; mrd_v[s] = 1'b1;
      for (int i = 0; i < 128; i++) begin mb[s][i] = 8'h0; mv[s][i] = 1'b0; end
    end
    rst = 1'b1;
    #3;
    for (int s = 0; s < 2; s++) begin
      chk("reset_rdata", rdata[s], 32'h0);
      chk("reset_ack",   {31'b0, ack[s]},  32'h0);
      chk("reset_err",   {31'b0, err[s]},  32'h0);
      chk("reset_busy",  {31'b0, busy[s]}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=1 directed: full word, byte lane, empty be, errors
    access(0, 1'b1, 32'h0,  32'h0BADCAFE, 4'hF);
    access(0, 1'b1, 32'h8,  32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 32'h8,  32'h0, 4'h0);
    chk("word_read", rdata[0], 32'hDEADBEEF);
    access(0, 1'b1, 32'h8,  32'h00000011, 4'h1);
    access(0, 1'b0, 32'h8,  32'h0, 4'h0);
    chk("lane0_read", rdata[0], 32'hDEADBE11);
    access(0, 1'b1, 32'h8,  32'hFFFFFFFF, 4'h0);
    access(0, 1'b0, 32'h8,  32'h0, 4'h0);
    chk("be0_read", rdata[0], 32'hDEADBE11);
    access(0, 1'b0, 32'h6,  32'h0, 4'h0);
    chk("misaligned_rdata", rdata[0], 32'h0);
    access(0, 1'b1, 32'h80, 32'h55555555, 4'hF);
    access(0, 1'b0, 32'h0,  32'h0, 4'h0);
    chk("after_err_read", rdata[0], 32'h0BADCAFE);

    // Asynchronous reset pulse with no clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdata", rdata[0], 32'h0);
    chk("async_rst_ack",   {31'b0, ack[0]},  32'h0);
    chk("async_rst_busy",  {31'b0, busy[0]}, 32'h0);
    chk("async_rst_err",   {31'b0, err[0]},  32'h0);
    #1 rst = 1'b0;
    mrd[0] = 32'h0; mrd[1] = 32'h0; mrd_v[0] = 1'b1; mrd_v[1] = 1'b1;

    // LATENCY=3 back-to-back reads with req held high
    bb_a[0] = 32'h10; bb_a[1] = 32'h14; bb_a[2] = 32'h18;
    access(1, 1'b1, 32'h10, 32'h11112222, 4'hF);
    access(1, 1'b1, 32'h14, 32'h33334444, 4'hF);
    access(1, 1'b1, 32'h18, 32'h55556666, 4'hF);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = bb_a[0]; be[1] = 4'h0;
    k = 0; t = 0; bc = 0;
    while (k < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (busy[1]) bc++;
      if (ack[1]) begin
        ack_t[k] = t;
        void'(model_apply(1, 1'b0, bb_a[k], 32'h0, 4'h0));
        chk("bb_rdata", rdata[1], mrd[1]);
        chk("bb_err", {31'b0, err[1]}, 32'h0);
        k++;
        if (k < 3) addr[1] = bb_a[k];
        else req[1] = 1'b0;
      end
    end
    req[1] = 1'b0;
    chk("bb_ack_count", 32'(k), 32'd3);
    if (k == 3) begin
      chk("bb_first_ack", 32'(ack_t[0]), 32'd4);
      chk("bb_spacing1", 32'(ack_t[1] - ack_t[0]), 32'd4);
      chk("bb_spacing2", 32'(ack_t[2] - ack_t[1]), 32'd4);
    end
    chk("bb_busy_cycles", 32'(bc), 32'd9);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[1]) extra++;
    end
    chk("bb_extra_ack", 32'(extra), 32'd0);

    // Reset during the second WAIT cycle of a LATENCY=3 write
    access(1, 1'b1, 32'hC, 32'h12345678, 4'hF);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'hC; wdata[1] = 32'hCAFEF00D; be[1] = 4'hF;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_busy", {31'b0, busy[1]}, 32'h0);
    chk("midop_ack",  {31'b0, ack[1]},  32'h0);
    @(negedge clk);
    rst = 1'b0;
    mrd[0] = 32'h0; mrd[1] = 32'h0; mrd_v[0] = 1'b1; mrd_v[1] = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[1]) extra++;
    end
    chk("midop_no_ack", 32'(extra), 32'd0);
    access(1, 1'b0, 32'hC, 32'h0, 4'h0);
    chk("midop_mem_kept", rdata[1], 32'h12345678);

    // Random mix across both instances
    for (int r = 0; r < 60; r++) begin
      int          s;
      int          sel;
      bit          w;
      logic [31:0] a;
      s   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = 32'($urandom_range(0, 31)) * 4;
      else if (sel == 8) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else               a = 32'h80 + 32'($urandom_range(0, 100)) * 4;
      access(s, w, a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_mem_latency.md
Name: data_mem_latency

Overview:
- Parametrised data memory for the CPU's MEM stage. Adds configurable width and depth, byte-lane write enables, a programmable access latency, and a req/ack handshake the pipeline stalls on.
- Same byte-addressed word store as the original data memory, with alignment and range checking.
- Single clock domain; sits between the pipeline's MEM stage and the hazard/stall unit.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8, at least 8.
- DEPTH, 32, number of words.
- ADDR_W, 32, width of the byte address input.
- LATENCY, 1, wait cycles between request acceptance and access commit; at least 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  access request; sampled on rising edge in IDLE or RESP.
- we_i  input  1  1 = write, 0 = read; sampled with req_i.
- addr_i  input  ADDR_W  byte address; sampled with req_i.
- wdata_i  input  DATA_W  write data; sampled with req_i.
- be_i  input  DATA_W/8  byte-lane write enables; sampled with req_i.
- rdata_o  output  DATA_W  read data.
- ack_o  output  1  one-cycle completion pulse.
- err_o  output  1  error flag, qualified by ack_o.
- busy_o  output  1  high while in WAIT; pipeline stalls on it.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, counter=0, latched request cleared.
  - rdata_o=0, ack_o=0, err_o=0, busy_o=0.
  - Memory array is NOT cleared; contents undefined until written.
- States: IDLE, WAIT, RESP.
  - IDLE: req_i=1 at edge -> latch we/addr/wdata/be, counter=LATENCY-1, go WAIT. Otherwise stay.
  - WAIT: busy_o=1; req_i is ignored. counter!=0 -> decrement. counter==0 -> commit access at this edge, go RESP.
  - RESP: ack_o=1 for exactly one cycle. req_i=1 at the edge -> latch new request and go WAIT (back-to-back); else go IDLE.
- Timing:
  - Request sampled at edge E0; WAIT occupies LATENCY cycles; ack_o high in cycle LATENCY+1 after E0.
  - Back-to-back throughput: one access per LATENCY+1 cycles.
- Addressing:
  - OFF = log2(DATA_W/8); word index = addr[ADDR_W-1:OFF].
  - Misaligned: addr[OFF-1:0] != 0 (only when DATA_W > 8).
  - Out of range: word index >= DEPTH.
- Error:
  - Misaligned or out-of-range -> err_o=1 with ack_o, no memory write, rdata_o=0.
  - err_o=0 whenever ack_o=0.
- Write commit:
  - Lane i receives wdata[8i+7:8i] only where be[i]=1; other lanes unchanged.
  - be=0 completes as a no-op with ack_o and err_o=0.
  - rdata_o is unchanged on writes.
- Read commit: rdata_o <= memory[index] at the commit edge; held until the next read ack or reset.
- Reset mid-operation: the in-flight access is aborted; no write is committed and no ack is issued.
- req_i held high continuously: re-accepted at every RESP edge, so no request is duplicated or lost.

Test Plan:
- Reset: rst_i pulsed mid-cycle, no clock edge -> rdata_o=0, ack_o=0, busy_o=0, err_o=0 immediately.
- Full-word write then read:
  - LATENCY=1: write addr=0x8, wdata=0xDEADBEEF, be=0xF, then read addr=0x8.
  - Required: each ack_o arrives 2 cycles after its request edge; busy_o high for 1 cycle; read returns rdata_o=0xDEADBEEF, err_o=0.
- Byte lanes:
  - After the word above, write addr=0x8, wdata=0x00000011, be=0x1, then read addr=0x8 -> 0xDEADBE11.
  - Then be=0x0 write -> read still returns 0xDEADBE11, with ack and err_o=0.
- Errors (DEPTH=32):
  - Read addr=0x6 (misaligned) -> ack_o with err_o=1, rdata_o=0.
  - Write addr=0x80 (index 32) -> err_o=1.
  - Follow-up read of addr=0x0 -> prior contents unchanged.
- Latency and back-to-back:
  - LATENCY=3, req_i held high for three reads.
  - Required: busy_o high 3 cycles per access; three ack_o pulses 4 cycles apart; no extra ack.
- Reset mid-operation:
  - LATENCY=3 write to 0xC asserted; rst_i raised during the second WAIT cycle.
  - Required: no ack_o; a later read of 0xC returns the previously written value.
